mem_arbiter: RTL and testbench

//   Shares one single-port Memory (ADDR_SIZE x WIDTH) between two requesters:

---
 rtl/mem_arbiter.sv | 136 +++++++++++++
 tb/tb_mem_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Round-robin arbiter sharing one single-port memory between requester A and B.
// One transaction at a time; memory controls and address are driven from registers.
module mem_arbiter #(
    parameter int ADDR_SIZE = 11,
    parameter int WIDTH     = 16,
    parameter int RD_LAT    = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 a_req,
    input  logic                 a_we,
    input  logic [ADDR_SIZE-1:0] a_addr,
    input  logic [WIDTH-1:0]     a_wdata,
    output logic                 a_gnt,
    output logic                 a_rvalid,
    output logic [WIDTH-1:0]     a_rdata,
    input  logic                 b_req,
    input  logic                 b_we,
    input  logic [ADDR_SIZE-1:0] b_addr,
    input  logic [WIDTH-1:0]     b_wdata,
    output logic                 b_gnt,
    output logic                 b_rvalid,
    output logic [WIDTH-1:0]     b_rdata,
    output logic [WIDTH-1:0]     mem_data,
    output logic [ADDR_SIZE-1:0] mem_addr,
    output logic                 mem_MR,
    output logic                 mem_MW,
    input  logic [WIDTH-1:0]     mem_out
);

    typedef enum logic [1:0] {IDLE, ACCESS, RWAIT, RDONE} state_t;

    state_t     state, state_nxt;
    logic       last_b, last_b_nxt;
    logic [2:0] cnt, cnt_nxt;
    logic       pick_b;
    logic       start;
    logic       win_we;

    // last_b doubles as the selector of the transaction in flight
    always_comb begin
        pick_b = 1'b0;
        if (a_req && b_req)
            pick_b = ~last_b;
        else
            pick_b = b_req;
        start  = (state == IDLE) && (a_req || b_req);
        win_we = pick_b ? b_we : a_we;
    end

    always_comb begin
        state_nxt  = state;
        last_b_nxt = last_b;
        cnt_nxt    = cnt;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nxt  = ACCESS;
                    last_b_nxt = pick_b;
                end
            end
            ACCESS: begin
                if (mem_MW) begin
                    state_nxt = IDLE;
                end else begin
                    state_nxt = RWAIT;
                    cnt_nxt   = 3'(RD_LAT - 1);
                end
            end
            RWAIT: begin
                if (cnt == 3'd0)
                    state_nxt = RDONE;
                else
                    cnt_nxt = cnt - 3'd1;
            end
            RDONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            last_b <= 1'b1;
            cnt    <= 3'd0;
        end else begin
            state  <= state_nxt;
            last_b <= last_b_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // Memory-side registers: loaded when IDLE is left, strobes cleared after ACCESS
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            mem_addr <= '0;
            mem_data <= '0;
            mem_MR   <= 1'b0;
            mem_MW   <= 1'b0;
        end else if (start) begin
            mem_addr <= pick_b ? b_addr : a_addr;
            mem_data <= pick_b ? b_wdata : a_wdata;
            mem_MW   <= win_we;
            mem_MR   <= ~win_we;
        end else if (state == ACCESS) begin
            mem_MR <= 1'b0;
            mem_MW <= 1'b0;
        end
    end

    // Read return: capture in RDONE, pulse rvalid for the following cycle
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            a_rdata  <= '0;
            b_rdata  <= '0;
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
        end else begin
            a_rvalid <= 1'b0;
            b_rvalid <= 1'b0;
            if (state == RDONE) begin
                if (last_b) begin
                    b_rdata  <= mem_out;
                    b_rvalid <= 1'b1;
                end else begin
                    a_rdata  <= mem_out;
                    a_rvalid <= 1'b1;
                end
            end
        end
    end

    assign a_gnt = (state == ACCESS) && !last_b;
    assign b_gnt = (state == ACCESS) && last_b;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural single-port memory (1-cycle read).
module tb_mem_arbiter;
    localparam int AW = 11;
    localparam int DW = 16;
    localparam int RD_LAT = 1;

    logic          clk = 1'b0;
    logic          reset;
    logic          a_req, a_we, b_req, b_we;
    logic [AW-1:0] a_addr, b_addr, mem_addr;
    logic [DW-1:0] a_wdata, b_wdata, a_rdata, b_rdata, mem_data, mem_out;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid, mem_MR, mem_MW;

    logic [DW-1:0] mem [0:(1<<AW)-1];

    int checks = 0;
    int failures = 0;
    int gnt_n = 0, a_gnt_n = 0, acc_n = 0, a_rv_n = 0;
    int both_gnt = 0, both_rv = 0, mr_mw = 0;
    bit gnt_log [0:255];

    mem_arbiter #(.ADDR_SIZE(AW), .WIDTH(DW), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .reset(reset),
        .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .mem_data(mem_data), .mem_addr(mem_addr), .mem_MR(mem_MR), .mem_MW(mem_MW),
        .mem_out(mem_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (mem_MW) mem[mem_addr] <= mem_data;
        mem_out <= mem[mem_addr];
    end

    always @(negedge clk) begin
        if (reset) begin
            if (a_gnt && gnt_n < 256) begin gnt_log[gnt_n] = 1'b0; gnt_n++; end
            if (b_gnt && gnt_n < 256) begin gnt_log[gnt_n] = 1'b1; gnt_n++; end
            if (a_gnt) a_gnt_n++;
            if (a_rvalid) a_rv_n++;
            if (mem_MR || mem_MW) acc_n++;
            if (a_gnt && b_gnt) both_gnt++;
            if (a_rvalid && b_rvalid) both_rv++;
            if (mem_MR && mem_MW) mr_mw++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Single transaction on one port, started in an IDLE cycle; returns cycle offsets of gnt/rvalid
    task automatic xfer(input bit pb, input bit we, input logic [AW-1:0] addr,
                        input logic [DW-1:0] wdata, output logic [DW-1:0] rdata,
                        output int gnt_c, output int rv_c);
        int c;
        c = 0; gnt_c = -1; rv_c = -1; rdata = '0;
        if (pb) begin b_req = 1; b_we = we; b_addr = addr; b_wdata = wdata; end
        else    begin a_req = 1; a_we = we; a_addr = addr; a_wdata = wdata; end
        while (c < 40 && ((we && gnt_c < 0) || (!we && rv_c < 0))) begin
            tick();
            c++;
            if ((pb ? b_gnt : a_gnt) && gnt_c < 0) begin
                gnt_c = c;
                if (pb) b_req = 0; else a_req = 0;
            end
            if (pb ? b_rvalid : a_rvalid) begin
                rv_c = c;
                rdata = pb ? b_rdata : a_rdata;
            end
        end
        a_req = 0;
        b_req = 0;
        if (we) tick();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] rd;
        int gc, rc, base, snap_a, snap_acc, snap_rv, c;

        reset = 0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;

        // 1: reset for 4 cycles, then simultaneous requests
        tick(); tick();
        chk("rst_ctl", {26'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, mem_MR, mem_MW}, 0);
        chk("rst_addr", 32'(mem_addr), 0);
        chk("rst_data", 32'(mem_data), 0);
        chk("rst_rdata", {a_rdata, b_rdata}, 0);
        tick(); tick();
        chk("rst_ctl4", {26'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, mem_MR, mem_MW}, 0);
        reset = 1;
        a_req = 1; a_we = 1; a_addr = 11'd100; a_wdata = 16'd1;
        b_req = 1; b_we = 1; b_addr = 11'd101; b_wdata = 16'd2;
        tick();
        chk("tie_a_gnt", 32'(a_gnt), 1);
        chk("tie_b_wait", 32'(b_gnt), 0);
        a_req = 0;
        tick();
        chk("tie_gap", {30'd0, a_gnt, b_gnt}, 0);
        tick();
        chk("tie_b_gnt", 32'(b_gnt), 1);
        b_req = 0;
        tick();

        // 2: A writes 8-i to addr i, then reads back
        for (int i = 0; i < 8; i++) begin
            xfer(0, 1, AW'(i), DW'(8 - i), rd, gc, rc);
            chk("wr_gnt_lat", gc, 1);
        end
        for (int i = 0; i < 8; i++) begin
            xfer(0, 0, AW'(i), '0, rd, gc, rc);
            chk("rd_data", 32'(rd), 8 - i);
            chk("rd_rv_lat", rc, 3 + RD_LAT);
        end

        // 3: B access first so A wins the next tie, then continuous dual requests
        xfer(1, 0, 11'd1, '0, rd, gc, rc);
        chk("b_rd1", 32'(rd), 7);
        base = gnt_n;
        a_req = 1; a_we = 0; a_addr = 11'd0;
        b_req = 1; b_we = 0; b_addr = 11'd1;
        c = 0;
        while (c < 200 && gnt_n - base < 8) begin
            tick();
            c++;
        end
        a_req = 0; b_req = 0;
        chk("rr_count", gnt_n - base, 8);
        for (int i = 0; i < 8; i++)
            chk("rr_order", 32'(gnt_log[base + i]), i % 2);
        for (int i = 0; i < 10; i++) tick();
        chk("no_dual_gnt", both_gnt, 0);
        chk("no_mr_mw", mr_mw, 0);
        chk("no_dual_rv", both_rv, 0);

        // 4: B write to addr 5, A read of addr 5 one cycle later
        b_req = 1; b_we = 1; b_addr = 11'd5; b_wdata = 16'hF00F;
        tick();
        chk("wr_b_first", {30'd0, a_gnt, b_gnt}, 1);
        b_req = 0;
        a_req = 1; a_we = 0; a_addr = 11'd5;
        c = 1; gc = -1; rc = -1;
        while (c < 40 && rc < 0) begin
            tick();
            c++;
            if (a_gnt && gc < 0) begin gc = c; a_req = 0; end
            if (a_rvalid) begin rc = c; rd = a_rdata; end
        end
        a_req = 0;
        chk("raw_a_gnt", gc, 3);
        chk("raw_rv_lat", rc, 5 + RD_LAT);
        chk("raw_data", 32'(rd), 32'hF00F);

        // 5: A pulses req for one cycle while B's read sits in RWAIT
        snap_a = a_gnt_n;
        snap_acc = acc_n;
        b_req = 1; b_we = 0; b_addr = 11'd2;
        tick();
        chk("b5_gnt", 32'(b_gnt), 1);
        b_req = 0;
        tick();
        a_req = 1; a_we = 1; a_addr = 11'd2; a_wdata = 16'hDEAD;
        tick();
        a_req = 0;
        for (int i = 3; i < 3 + RD_LAT; i++) tick();
        chk("b5_rvalid", 32'(b_rvalid), 1);
        chk("b5_rdata", 32'(b_rdata), 6);
        for (int i = 0; i < 6; i++) tick();
        chk("a5_no_gnt", a_gnt_n - snap_a, 0);
        chk("a5_no_access", acc_n - snap_acc, 1);

        // 6: reset during RWAIT of an A read
        snap_rv = a_rv_n;
        a_req = 1; a_we = 0; a_addr = 11'd4;
        tick();
        chk("r6_gnt", 32'(a_gnt), 1);
        a_req = 0;
        tick();
        #2;
        reset = 0;
        #1;
        chk("r6_ctl", {26'd0, a_gnt, b_gnt, a_rvalid, b_rvalid, mem_MR, mem_MW}, 0);
        chk("r6_addr", 32'(mem_addr), 0);
        chk("r6_rdata", 32'(a_rdata), 0);
        @(posedge clk); @(posedge clk); #1;
        reset = 1;
        for (int i = 0; i < 6; i++) tick();
        chk("r6_no_rvalid", a_rv_n - snap_rv, 0);
        xfer(0, 0, 11'd3, '0, rd, gc, rc);
        chk("r6_rd3", 32'(rd), 5);
        chk("r6_rd3_lat", rc, 3 + RD_LAT);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
